pc_gen: RTL and testbench
=========================

// Module: pc_gen
// PURPOSE
//  Parametrised fetch-stage PC generator, successor to the fixed 32-bit PC register. Holds the
//  fetch PC, sequences boot after reset, and steps by STEP per accepted fetch. Applies flush and
//  branch redirects, buffering a redirect that arrives while fetch cannot advance so it is never
//  lost. Sits ahead of the instruction memory port and is driven by the stall controller and EX/MEM.
// PARAMETERS
//  ADDR_W        32        PC / target width in bits
//  RESET_VECTOR  32'h0     PC value after boot
//  STEP          4         sequential increment in bytes
//  STALL_W       6         stall vector width; only bit 0 (PC stage) is used
//  EXC_VECTOR    32'h20    misalign trap target (used only with PC_ALIGN_CHECK_EN)
// PORTS
//  clk                      in   1        clock, all state updates on rising edge
//  rst                      in   1        asynchronous, active-low reset (0 = reset)
//  stall                    in   STALL_W  stall vector; stall[0]=1 freezes PC
//  flush_i                  in   1        exception/flush redirect request, 1-cycle pulse
//  new_pc_i                 in   ADDR_W   flush target, valid with flush_i
//  branch_flag_i            in   1        branch taken, 1-cycle pulse
//  branch_target_address_i  in   ADDR_W   branch target, valid with branch_flag_i
//  if_ready_i               in   1        instruction memory accepts request this cycle
//  pc                       out  ADDR_W   current fetch address
//  ce                       out  1        fetch request valid / memory chip enable
//  redirect_pend_o          out  1        a buffered redirect is waiting
//  misalign_o               out  1        misaligned target trapped (0 without macro)
// BEHAVIOUR
//  - Reset (rst=0, async): state=RST, pc=RESET_VECTOR, ce=0, pending buffer cleared,
//    redirect_pend_o=0, misalign_o=0.
//  - FSM RST -> BOOT on first edge with rst=1; BOOT -> RUN next edge (ce=1 from entering RUN).
//    pc stays RESET_VECTOR through RST and BOOT; redirect inputs ignored in RST/BOOT.
//  - advance = (state==RUN) && !stall[0] && if_ready_i.
//  - Next-PC priority at each edge in RUN: flush_i > branch_flag_i > pending buffer > pc+STEP.
//  - Redirect present this cycle (input or buffer) and advance=1: pc <= target in that cycle;
//    buffer cleared.
//  - Redirect input and advance=0: target latched into buffer (flush overwrites a buffered
//    branch; branch never overwrites a buffered flush); pc holds; redirect_pend_o=1 next cycle.
//  - No redirect, advance=1: pc <= pc+STEP, mod 2^ADDR_W (wraps to 0 silently).
//  - No redirect, advance=0: pc holds.
//  - stall[STALL_W-1:1] ignored. ce stays 1 in RUN regardless of stall.
//  - rst asserted mid-operation: immediate return to reset values; buffered redirect discarded.
//  - Latency: redirect visible on pc the cycle after the accepting edge; one cycle per step.
// CONFIGURATION
//  PC_ALIGN_CHECK_EN defined:
//    - Applied target with low 2 bits !=0: pc <= EXC_VECTOR instead of the target.
//    - misalign_o=1 for exactly the cycle after that edge.
//    - Check happens at apply time, not at buffer time.
//  PC_ALIGN_CHECK_EN undefined:
//    - Target low 2 bits forced to 0 on apply; misalign_o tied 0.
// TESTING
//  1. rst low 3 cycles, then high: ce=0,pc=0 in RST/BOOT; ce=1 at RUN; pc 0,4,8,C on ready=1.
//  2. RUN, pc=0x10, branch to 0x100 with ready=1,stall=0: next pc=0x100, then 0x104.
//  3. stall[0]=1 held 3 cycles, branch to 0x200 on 1st stalled cycle: pc held, pend=1;
//     stall release: pc=0x200, pend=0.
//  4. Same cycle flush(0x80) and branch(0x300): pc=0x80; flush buffered under stall then
//     branch arrives: flush target wins on release.
//  5. RESET_VECTOR=32'hFFFF_FFFC: after boot, one advance -> pc wraps to 0x0.
//  6. Branch to 0x102: with PC_ALIGN_CHECK_EN pc=0x20, misalign_o pulses 1 cycle;
//     without macro pc=0x100, misalign_o=0.

Source files
------------

// File: rtl/pc_gen_if.sv
// Fetch-side bundle for pc_gen: stall/redirect/ready inputs and the fetch PC outputs.
// master = stall controller / EX-MEM / imem side, slave = pc_gen.
interface pc_gen_if #(
  parameter int ADDR_W  = 32,
  parameter int STALL_W = 6
);
  logic [STALL_W-1:0] stall;
  logic               flush_i;
  logic [ADDR_W-1:0]  new_pc_i;
  logic               branch_flag_i;
  logic [ADDR_W-1:0]  branch_target_address_i;
  logic               if_ready_i;
  logic [ADDR_W-1:0]  pc;
  logic               ce;
  logic               redirect_pend_o;
  logic               misalign_o;

  modport master (
    output stall, flush_i, new_pc_i, branch_flag_i, branch_target_address_i, if_ready_i,
    input  pc, ce, redirect_pend_o, misalign_o
  );

  modport slave (
    input  stall, flush_i, new_pc_i, branch_flag_i, branch_target_address_i, if_ready_i,
    output pc, ce, redirect_pend_o, misalign_o
  );
endinterface

// File: rtl/pc_gen.sv
// Fetch-stage PC generator: boot sequencing, sequential stepping, flush/branch redirects with a
// one-entry redirect buffer. Optional macro PC_ALIGN_CHECK_EN traps misaligned targets to EXC_VECTOR.
module pc_gen #(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter int                STEP         = 4,
  parameter int                STALL_W      = 6,
  parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(32'h20)
) (
  input logic     clk,
  input logic     rst,
  pc_gen_if.slave bus
);

  typedef enum logic [1:0] {ST_RST, ST_BOOT, ST_RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic              pend_q, pend_d;
  logic              pend_flush_q, pend_flush_d;
  logic              ce_q, ce_d;
  logic              mis_q, mis_d;

  logic              advance;
  logic              redir;
  logic [ADDR_W-1:0] redir_pc;
  logic [ADDR_W-1:0] applied_pc;
  logic              applied_mis;

  // Upper stall bits belong to later pipeline stages and are deliberately unused here.
  logic unused_stall;
  assign unused_stall = ^bus.stall[STALL_W-1:1];

  always_comb begin
    advance  = (state_q == ST_RUN) && !bus.stall[0] && bus.if_ready_i;
    redir    = 1'b1;
    redir_pc = pend_pc_q;
    if (bus.flush_i) begin
      redir_pc = bus.new_pc_i;
    end else if (bus.branch_flag_i) begin
      redir_pc = bus.branch_target_address_i;
    end else if (!pend_q) begin
      redir = 1'b0;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_comb begin
    applied_mis = (redir_pc[1:0] != 2'b00);
    applied_pc  = applied_mis ? EXC_VECTOR : redir_pc;
  end
`else
  logic unused_exc;
  assign unused_exc  = ^EXC_VECTOR;
  assign applied_mis = 1'b0;
  assign applied_pc  = {redir_pc[ADDR_W-1:2], 2'b00};
`endif

  // Redirects arriving while fetch is blocked go to the buffer; a buffered flush is never
  // displaced by a later branch, but a live redirect input outranks the buffer on apply.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_pc_d    = pend_pc_q;
    pend_d       = pend_q;
    pend_flush_d = pend_flush_q;
    ce_d         = ce_q;
    mis_d        = 1'b0;
    unique case (state_q)
      ST_RST: state_d = ST_BOOT;
      ST_BOOT: begin
        state_d = ST_RUN;
        ce_d    = 1'b1;
      end
      ST_RUN: begin
        if (advance) begin
          if (redir) begin
            pc_d  = applied_pc;
            mis_d = applied_mis;
          end else begin
            pc_d = pc_q + ADDR_W'(STEP);
          end
          pend_d       = 1'b0;
          pend_flush_d = 1'b0;
        end else if (bus.flush_i) begin
          pend_d       = 1'b1;
          pend_flush_d = 1'b1;
          pend_pc_d    = bus.new_pc_i;
        end else if (bus.branch_flag_i && !(pend_q && pend_flush_q)) begin
          pend_d       = 1'b1;
          pend_flush_d = 1'b0;
          pend_pc_d    = bus.branch_target_address_i;
        end
      end
      default: state_d = ST_RST;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_RST;
      pc_q         <= RESET_VECTOR;
      pend_pc_q    <= '0;
      pend_q       <= 1'b0;
      pend_flush_q <= 1'b0;
      ce_q         <= 1'b0;
      mis_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_pc_q    <= pend_pc_d;
      pend_q       <= pend_d;
      pend_flush_q <= pend_flush_d;
      ce_q         <= ce_d;
      mis_q        <= mis_d;
    end
  end

  assign bus.pc              = pc_q;
  assign bus.ce              = ce_q;
  assign bus.redirect_pend_o = pend_q;
  assign bus.misalign_o      = mis_q;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: stimulus pushes model expectations, a monitor pops and compares.
// A second instance with RESET_VECTOR=0xFFFF_FFFC checks the address wrap after boot.
module tb_pc_gen;

  typedef struct packed {
    logic [31:0] pc;
    logic        ce;
    logic        pend;
    logic        mis;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wrap_rst_n = 1'b0;
  always #5 clk = ~clk;

  pc_gen_if #(.ADDR_W(32), .STALL_W(6)) bus ();
  pc_gen_if #(.ADDR_W(32), .STALL_W(6)) wbus ();

  pc_gen dut (.clk(clk), .rst(rst_n), .bus(bus.slave));
  pc_gen #(.RESET_VECTOR(32'hFFFF_FFFC)) dut_wrap (.clk(clk), .rst(wrap_rst_n), .bus(wbus.slave));

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   started = 1'b0;
  bit   done = 1'b0;

  // Reference model: boot edge count, current pc, and the buffered redirect (0 none, 1 branch, 2 flush).
  logic [31:0] m_pc = 32'h0;
  int          m_boot = 0;
  int          m_kind = 0;
  logic [31:0] m_pend_pc = 32'h0;

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkValue("pc", bus.pc, e.pc);
    checkValue("ce", {31'b0, bus.ce}, {31'b0, e.ce});
    checkValue("redirect_pend", {31'b0, bus.redirect_pend_o}, {31'b0, e.pend});
    checkValue("misalign", {31'b0, bus.misalign_o}, {31'b0, e.mis});
  endtask

  function automatic logic [31:0] target_after_apply(input logic [31:0] t, output logic mis);
`ifdef PC_ALIGN_CHECK_EN
    mis = (t % 4) != 0;
    return mis ? 32'h20 : t;
`else
    mis = 1'b0;
    return t - (t % 4);
`endif
  endfunction

  task automatic applyStimulus(input bit r, input logic [5:0] st, input bit fl, input logic [31:0] fpc,
                               input bit br, input logic [31:0] bpc, input bit rdy);
    exp_t        e;
    logic        mis;
    logic [31:0] t;
    bit          have;
    @(negedge clk);
    rst_n                       = r;
    bus.stall                   = st;
    bus.flush_i                 = fl;
    bus.new_pc_i                = fpc;
    bus.branch_flag_i           = br;
    bus.branch_target_address_i = bpc;
    bus.if_ready_i              = rdy;
    mis = 1'b0;
    if (!r) begin
      m_boot = 0; m_pc = 32'h0; m_kind = 0; m_pend_pc = 32'h0;
    end else begin
      if (m_boot >= 2) begin
        have = 1'b1;
        if (fl) t = fpc;
        else if (br) t = bpc;
        else if (m_kind != 0) t = m_pend_pc;
        else begin have = 1'b0; t = 32'h0; end
        if (!st[0] && rdy) begin
          m_pc   = have ? target_after_apply(t, mis) : m_pc + 32'd4;
          m_kind = 0;
        end else if (fl) begin
          m_kind = 2; m_pend_pc = fpc;
        end else if (br && m_kind != 2) begin
          m_kind = 1; m_pend_pc = bpc;
        end
      end
      if (m_boot < 2) m_boot++;
    end
    e.pc   = m_pc;
    e.ce   = (r && m_boot >= 2);
    e.pend = (m_kind != 0);
    e.mis  = mis;
    exp_q.push_back(e);
    started = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end else if (started && !done) begin
        checks++;
        errors++;
        $display("[TB] FAIL scoreboard at %0t: got empty queue expected an entry", $time);
      end
    end
  end

  initial begin : stimulus
    logic [31:0] t1, t2;
    logic [5:0]  st;
    bus.stall = '0; bus.flush_i = 1'b0; bus.new_pc_i = '0;
    bus.branch_flag_i = 1'b0; bus.branch_target_address_i = '0; bus.if_ready_i = 1'b0;
    wbus.stall = '0; wbus.flush_i = 1'b0; wbus.new_pc_i = '0;
    wbus.branch_flag_i = 1'b0; wbus.branch_target_address_i = '0; wbus.if_ready_i = 1'b1;

    repeat (3) applyStimulus(0, 6'd0, 0, 0, 0, 0, 1);
    repeat (6) applyStimulus(1, 6'd0, 0, 0, 0, 0, 1);
    applyStimulus(1, 6'd0, 0, 0, 1, 32'h100, 1);
    applyStimulus(1, 6'd0, 0, 0, 0, 0, 1);
    applyStimulus(1, 6'd1, 0, 0, 1, 32'h200, 1);
    applyStimulus(1, 6'd1, 0, 0, 0, 0, 1);
    applyStimulus(1, 6'd1, 0, 0, 0, 0, 1);
    applyStimulus(1, 6'd0, 0, 0, 0, 0, 1);
    applyStimulus(1, 6'd0, 1, 32'h80, 1, 32'h300, 1);
    applyStimulus(1, 6'd1, 1, 32'h400, 0, 0, 1);
    applyStimulus(1, 6'd1, 0, 0, 1, 32'h500, 1);
    applyStimulus(1, 6'd0, 0, 0, 0, 0, 1);
    applyStimulus(1, 6'd0, 0, 0, 1, 32'h102, 1);
    applyStimulus(1, 6'd0, 0, 0, 0, 0, 1);
    applyStimulus(1, 6'd0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      st = 6'($urandom);
      st[0] = ($urandom_range(0, 9) < 3);
      t1 = ($urandom & 32'h0000_0FFC) | (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
      t2 = ($urandom & 32'h0000_0FFC) | (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
      applyStimulus((i < 200 || i > 201), st, ($urandom_range(0, 9) == 0), t1,
                    ($urandom_range(0, 99) < 15), t2, ($urandom_range(0, 9) < 8));
    end
    @(posedge clk);
    #2;
    done = 1'b1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard drain: got %0d entries expected 0", exp_q.size());
    end

    @(negedge clk);
    wrap_rst_n = 1'b1;
    @(posedge clk); #2;
    checkValue("wrap boot pc", wbus.pc, 32'hFFFF_FFFC);
    checkValue("wrap boot ce", {31'b0, wbus.ce}, 32'h0);
    @(posedge clk); #2;
    checkValue("wrap run pc", wbus.pc, 32'hFFFF_FFFC);
    checkValue("wrap run ce", {31'b0, wbus.ce}, 32'h1);
    @(posedge clk); #2;
    checkValue("wrap pc", wbus.pc, 32'h0);
    @(posedge clk); #2;
    checkValue("wrap next pc", wbus.pc, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
